contador_ud_param: RTL
======================

Name: contador_ud_param

Overview:
Parametrised up/down counter with a built-in tick prescaler, synchronous load, programmable modulus and a terminal-count pulse. Counting advances on a prescaler tick, used as a clock-enable; there is no derived clock, so all logic runs on clk. It drives LED/7-segment display paths and cascades into other counters through tc.

Parameters:
WIDTH, 4, counter width in bits
MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH
DIV, 25000000, clk cycles per count step; DIV>=1; prescaler width = max(1,$clog2(DIV))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable, sampled only on tick cycles
rev  in  1  direction: 1 = up, 0 = down
load  in  1  synchronous load strobe
load_val  in  WIDTH  value for load
out  out  WIDTH  current count
tick  out  1  one-clk prescaler pulse
tc  out  1  one-clk terminal-count pulse

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, prescaler=0, tick=0, tc=0. Outputs hold reset values until the first clk edge after rst_n rises. Reset asserted mid-count clears everything immediately, with no wait for clk.
- Prescaler: free-runs 0..DIV-1, independent of en and rev. tick is registered: it is 1 for exactly the one clk after the prescaler is at DIV-1, when it wraps to 0. With DIV=1, tick is 1 every cycle after the first post-reset edge.
- Load has the highest priority and acts on the clk edge where load=1, regardless of tick and en:
  - out <= load_val if load_val<MODULO; otherwise out <= 0.
  - Prescaler is cleared to 0, so the next step comes DIV cycles later.
  - tc = 0 on that cycle.
- Step: on a cycle where tick=1, en=1 and load=0:
  - rev=1, up: out<MODULO-1 gives out+1; out==MODULO-1 is the wrap event.
  - rev=0, down: out>0 gives out-1; out==0 is the wrap event.
- Wrap event, default build: the counter wraps. Up goes to 0; down goes to MODULO-1.
- tc: registered and asserted for one clk in the same cycle the wrapped value appears on out. It asserts only on wrap events, never on load and never when en=0.
- en=0 on a tick cycle: out holds, the tick is consumed, and there is no catch-up later.
- A rev change takes effect on the next step; there is no glitch and no extra step.
- Arithmetic is modulo MODULO only, never natural 2**WIDTH overflow. For example, WIDTH=4 and MODULO=10 counts 9->0 up and 0->9 down; values 10..15 are never reachable.
- Latency: one clk from the qualifying tick/load edge to the out update. tick, tc and out are all registered, with no combinational paths from inputs to outputs.

Optional Feature:
Macro CONTADOR_SAT_EN.
- Defined: saturating mode. On a wrap event out holds at its bound: MODULO-1 when counting up, 0 when counting down. tc still pulses one clk on every attempted step past the bound, including repeated ticks while saturated. Reversing direction leaves the bound normally.
- Undefined: wrap-around as specified in Behaviour.

Test Plan:
- Reset: WIDTH=4, MODULO=16, DIV=4, counting up. Assert rst_n=0 between clk edges -> out=0, tick=0, tc=0 immediately. After release, the first tick appears on the 4th clk edge.
- Up wrap: MODULO=10, DIV=1, en=1, rev=1, from 0 for 12 ticks -> out 1..9,0,1,2. tc=1 only on the cycle out returns to 0.
- Down wrap: MODULO=10, DIV=2, rev=0, load_val=1, then load -> out=1. Next ticks -> out 0 then 9; tc pulses with out=9. With CONTADOR_SAT_EN -> out stays 0 and tc pulses on each tick.
- Load priority: load=1 with load_val=7 on a tick cycle with en=1 -> out=7, no step, tc=0, prescaler restarted. load_val=12 with MODULO=10 -> out=0.
- Enable/direction: DIV=3. Set en=0 across 2 ticks -> out unchanged. Toggle rev between ticks -> exactly one step per tick, in the newly selected direction.
- Default DIV=25000000, checked by counter observation: tick period = 25000000 clk cycles.

Source files
------------

// File: rtl/contador_ud_param.sv
// ============================================================================
// Module   : contador_ud_param
// Purpose  : Up/down modulo counter stepped by an internal prescaler tick,
//            with synchronous load and a one-clk terminal-count pulse.
//            Define CONTADOR_SAT_EN to saturate at the bounds instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_ud_param #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16,
    parameter int DIV    = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rev,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc
);

    localparam int               C_PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_PW-1:0]  C_PRE_LAST = C_PW'(DIV - 1);
    localparam logic [WIDTH-1:0] C_TOP      = WIDTH'(MODULO - 1);

    logic [C_PW-1:0]  r_pre;
    logic [WIDTH-1:0] r_out;
    logic             r_tick;
    logic             r_tc;

    logic             w_pre_last;
    logic             w_load_ok;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next;

    assign w_pre_last = (r_pre == C_PRE_LAST);
    // Compare at 32 bits so that MODULO == 2**WIDTH accepts every load value.
    assign w_load_ok  = (32'(load_val) < 32'(MODULO));

    always_comb begin
        w_next = r_out;
        w_wrap = 1'b0;
        if (rev) begin
            if (r_out == C_TOP) begin
                w_wrap = 1'b1;
`ifdef CONTADOR_SAT_EN
                w_next = C_TOP;
`else
                w_next = '0;
`endif
            end else begin
                w_next = r_out + WIDTH'(1);
            end
        end else begin
            if (r_out == '0) begin
                w_wrap = 1'b1;
`ifdef CONTADOR_SAT_EN
                w_next = '0;
`else
                w_next = C_TOP;
`endif
            end else begin
                w_next = r_out - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_out  <= '0;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else if (load) begin
            // Load restarts the prescaler, so any pending tick is dropped.
            r_out  <= w_load_ok ? load_val : '0;
            r_pre  <= '0;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_pre  <= w_pre_last ? '0 : r_pre + C_PW'(1);
            r_tick <= w_pre_last;
            r_tc   <= 1'b0;
            if (r_tick && en) begin
                r_out <= w_next;
                r_tc  <= w_wrap;
            end
        end
    end

    assign out  = r_out;
    assign tick = r_tick;
    assign tc   = r_tc;

endmodule

`default_nettype wire
